// File: rtl/prog_ctr_if.sv
// rtl/prog_ctr_if.sv - prog_ctr control, target-LUT programming and status bundle
interface prog_ctr_if #(
    parameter int PC_W  = 10,
    parameter int LUT_W = 5
);
    logic             start;
    logic             halt_req;
    logic             branch_en;
    logic             jump_en;
    logic             alu_flag;
    logic [LUT_W-1:0] tgt_sel;
    logic             lut_wr_en;
    logic [LUT_W-1:0] lut_wr_addr;
    logic [PC_W-1:0]  lut_wr_data;
    logic [PC_W-1:0]  pc;
    logic             running;
    logic             done;
    logic             taken;
    logic             wrap_err;

    modport master (
        output start, halt_req, branch_en, jump_en, alu_flag, tgt_sel,
               lut_wr_en, lut_wr_addr, lut_wr_data,
        input  pc, running, done, taken, wrap_err
    );

    modport slave (
        input  start, halt_req, branch_en, jump_en, alu_flag, tgt_sel,
               lut_wr_en, lut_wr_addr, lut_wr_data,
        output pc, running, done, taken, wrap_err
    );
endinterface

// File: rtl/prog_ctr.sv
// rtl/prog_ctr.sv - program counter / next-PC sequencer with target LUT (option: PROG_CTR_REL_BRANCH_EN)
module prog_ctr #(
    parameter int PC_W     = 10,
    parameter int LUT_W    = 5,
    parameter int RESET_PC = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    prog_ctr_if.slave   bus
);
    localparam int              LUT_N   = 1 << LUT_W;
    localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic            taken_q, taken_nxt;
    logic            wrap_q, wrap_nxt;
    logic [PC_W-1:0] lut [LUT_N];
    logic [PC_W-1:0] lut_rd;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_tgt;

    // Read from the registered array, so a same-cycle write is seen only next cycle.
    assign lut_rd = lut[bus.tgt_sel];
    assign pc_inc = pc_q + PC_W'(1);

`ifdef PROG_CTR_REL_BRANCH_EN
    assign br_tgt = pc_q + lut_rd;
`else
    assign br_tgt = lut_rd;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            pc_q    <= PC_INIT;
            taken_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            taken_q <= taken_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
        end else if (bus.lut_wr_en) begin
            lut[bus.lut_wr_addr] <= bus.lut_wr_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start)    state_nxt = RUN;
            RUN:        if (bus.halt_req) state_nxt = DONE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_nxt    = pc_q;
        taken_nxt = 1'b0;
        wrap_nxt  = wrap_q;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    pc_nxt   = PC_INIT;
                    wrap_nxt = 1'b0;
                end
            end
            RUN: begin
                if (bus.halt_req) begin
                    pc_nxt = pc_q;
                end else if (bus.jump_en) begin
                    pc_nxt    = lut_rd;
                    taken_nxt = 1'b1;
                end else if (bus.branch_en && bus.alu_flag) begin
                    pc_nxt    = br_tgt;
                    taken_nxt = 1'b1;
                end else begin
                    pc_nxt = pc_inc;
                    if (&pc_q) wrap_nxt = 1'b1;
                end
            end
            default: begin
                pc_nxt = PC_INIT;
            end
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.running  = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.taken    = taken_q;
    assign bus.wrap_err = wrap_q;
endmodule
